// File: rtl/div_unit.sv
// Iterative restoring RV32M divider (DIV/DIVU/REM/REMU) for the execute stage.
// Define DIV_RADIX4_EN to retire two quotient bits per cycle.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_en,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             advance,
    input  logic             flush,
    output logic             div_ready,
    output logic [WIDTH-1:0] div_result,
    output logic             div_busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef DIV_RADIX4_EN
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-2);
`else
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic               rem_sel_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dsr_q;
    logic [WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               dvd_neg;
    logic               dsr_neg;
    logic [WIDTH-1:0]   dvd_abs;
    logic [WIDTH-1:0]   dsr_abs;
    logic               div_zero;
    logic               overflow;
    logic [2*WIDTH-1:0] step1;
    logic [2*WIDTH-1:0] step_out;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_val;

    // One restoring step: shift {rem, q} left, keep rem - d when it does not borrow.
    function automatic logic [2*WIDTH-1:0] restore_step(
        input logic [WIDTH-1:0] r,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0] shifted;
        logic [WIDTH:0] trial;
        shifted = {r, q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        if (!trial[WIDTH])
            return {trial[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
        else
            return {shifted[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        dvd_neg  = ~div_op[0] & dividend[WIDTH-1];
        dsr_neg  = ~div_op[0] & divisor[WIDTH-1];
        dvd_abs  = dvd_neg ? -dividend : dividend;
        dsr_abs  = dsr_neg ? -divisor : divisor;
        div_zero = (divisor == '0);
        overflow = ~div_op[0] && (dividend == MIN_NEG) && (divisor == '1);
    end

    always_comb begin
        step1 = restore_step(rem_q, quo_q, dsr_q);
`ifdef DIV_RADIX4_EN
        step_out = restore_step(step1[2*WIDTH-1:WIDTH], step1[WIDTH-1:0], dsr_q);
`else
        step_out = step1;
`endif
    end

    // Special cases load their final values with both sign flags clear, so the fix-up passes them through.
    always_comb begin
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        fix_val = rem_sel_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem_sel_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dsr_q     <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
        end else begin
            if (state == DONE)
                res_q <= fix_val;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (div_en) begin
                            rem_sel_q <= div_op[1];
                            dsr_q     <= dsr_abs;
                            cnt_q     <= '0;
                            if (div_zero) begin
                                quo_q     <= '1;
                                rem_q     <= dividend;
                                neg_quo_q <= 1'b0;
                                neg_rem_q <= 1'b0;
                                state     <= DONE;
                            end else if (overflow) begin
                                quo_q     <= MIN_NEG;
                                rem_q     <= '0;
                                neg_quo_q <= 1'b0;
                                neg_rem_q <= 1'b0;
                                state     <= DONE;
                            end else begin
                                quo_q     <= dvd_abs;
                                rem_q     <= '0;
                                neg_quo_q <= dvd_neg ^ dsr_neg;
                                neg_rem_q <= dvd_neg;
                                state     <= BUSY;
                            end
                        end
                    end
                    BUSY: begin
                        if (!div_en) begin
                            state <= IDLE;
                        end else begin
                            {rem_q, quo_q} <= step_out;
                            cnt_q          <= cnt_q + CNT_STEP;
                            if (cnt_q == CNT_LAST)
                                state <= DONE;
                        end
                    end
                    DONE: begin
                        if (!div_en || advance)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign div_busy   = (state == BUSY);
    assign div_ready  = (state == DONE);
    assign div_result = (state == DONE) ? fix_val : res_q;

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider for the execute stage. It computes DIV/DIVU/REM/REMU over many cycles and drives `div_ready`, which the hazard unit uses to decide the stall. While the execute-stage instruction is a divide and `div_ready` is low, the hazard unit stalls fetch/decode/execute and bubbles memory. The result is presented to the execute→memory register.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must be even.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `div_en`  in  1  execute stage holds a divide-class instruction.
- `div_op`  in  2  instruction funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend`  in  WIDTH  rs1 value (forwarded).
- `divisor`  in  WIDTH  rs2 value (forwarded).
- `advance`  in  1  execute→memory register is enabled this cycle, meaning the result is consumed.
- `flush`  in  1  execute stage is being flushed this cycle.
- `div_ready`  out  1  `div_result` is valid.
- `div_result`  out  WIDTH  quotient or remainder, per `div_op`.
- `div_busy`  out  1  iteration in progress.

## Operation
- **State machine:** IDLE, BUSY, DONE.
- **IDLE, `div_en`=1, no flush:**
  - Latch `div_op` and the operand signs (signed ops only).
  - Latch |dividend| into the quotient shift register and |divisor| into the divisor register.
  - Clear the remainder register and the iteration counter.
- **Special cases, decided in the IDLE cycle; both go straight to DONE and skip BUSY:**
  - Divisor == 0: quotient = all ones; remainder = dividend.
  - Signed op with dividend = 100…0 and divisor = all ones: quotient = 100…0; remainder = 0.
- **Normal case:** go to BUSY.
- **BUSY, one restoring iteration per cycle:**
  - Form {rem, q} <<= 1, then trial = rem − divisor, computed WIDTH+1 bits wide.
  - If the trial is non-negative: rem = trial and q[0] = 1; otherwise q[0] = 0.
  - Counter increments. After iteration WIDTH−1 the next state is DONE.
- **DONE:**
  - `div_ready` = 1.
  - `div_result` is the combinational sign fix-up of the latched registers:
    - Quotient is negated when the signs differ (signed op).
    - Remainder takes the dividend's sign (signed op).
    - Special-case values bypass the fix-up.
  - Stays in DONE until `advance` = 1, then goes to IDLE.
- **Priority, highest first:** `rst` > `flush` > `div_en`=0 > normal progress.
  - `flush` in any state → IDLE next cycle.
  - `div_en`=0 while in BUSY or DONE → IDLE (squashed instruction).
- **Ignored inputs:**
  - Operand and `div_op` changes during BUSY/DONE.
  - `advance` while in BUSY.
- **Back-to-back divides:** `advance` in DONE → IDLE. If `div_en` is still high the following cycle, that cycle starts the new divide.
- **Outputs by state:**
  - `div_busy` = (state == BUSY).
  - `div_ready` = (state == DONE).
  - `div_result` holds its last value outside DONE.

## Timing
- **Reset values:** state IDLE, all registers 0, `div_ready`=0, `div_busy`=0, `div_result`=0.
- **Cycle numbering:** cycle 0 is the first edge where IDLE samples `div_en`=1.
- **Normal latency:**
  - BUSY during cycles 1..WIDTH.
  - `div_ready`=1 from cycle WIDTH+1 (33 for WIDTH=32).
  - `div_ready` stays high until the edge where `advance`=1.
- **Special-case latency:** `div_ready`=1 in cycle 1.
- **Minimum gap** between consecutive divide starts is 1 cycle (the IDLE cycle after DONE).
- **Reset mid-operation:** IDLE next edge; no partial result is visible.
- **No combinational path** from inputs to `div_ready`/`div_busy`. `div_result` depends only on registers.

## Configuration
- **`DIV_RADIX4_EN` defined:**
  - Two restoring iterations are chained per cycle; the counter steps by 2.
  - BUSY lasts WIDTH/2 cycles, so `div_ready` rises at cycle WIDTH/2+1 (17).
  - Special-case latency is unchanged. Results are bit-identical.
- **`DIV_RADIX4_EN` undefined:** one iteration per cycle, as above.

## Test plan
- **DIV 100 / 7:** `div_en`=1, `advance` held 0 → `div_ready` rises at cycle 33 (17 with `DIV_RADIX4_EN`), result 14. Same operands with REM → 2. `advance`=1 → IDLE, `div_ready`=0 the next cycle.
- **Signed:**
  - DIV −7 / 2 → 0xFFFFFFFD (−3).
  - REM −7 / 2 → 0xFFFFFFFF (−1).
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - REMU 0xFFFFFFF9 / 2 → 1.
- **Special cases:**
  - DIV 5 / 0 → 0xFFFFFFFF, `div_ready` at cycle 1.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, with REM → 0, both at cycle 1.
- **Flush and squash:**
  - `flush`=1 at cycle 10 → IDLE at cycle 11, `div_busy`=0, no `div_ready`.
  - `div_en` dropped mid-BUSY → IDLE.
  - `rst`=1 at cycle 20 → all outputs at reset values next cycle.
- **Back-to-back:**
  - DIVU 50/5 completes; `advance`=1 with `div_en` held high and operands switched to 81/9 → second start one cycle after DONE; results 10 then 9.
  - Separately, with `advance` held 0 for 5 cycles in DONE, `div_ready` stays 1 and the result is stable.
